// File: rtl/md_arbiter.sv
// md_arbiter: round-robin arbiter and sequencer sharing one multiply/divide
// unit (HI/LO) between two requesters. One operation is in flight at a time.
// It drives the MD start/way/HIw/LOw controls, waits out the busy period and
// returns a one-cycle response to the requester that issued the operation.
//
// Ports
//   clk, reset               clock (rising edge), async active-high reset
//   reqN_valid/op/a/b        request N (N=0,1); held stable until accepted
//   reqN_ready               accept strobe, combinational, IDLE only
//   respN_valid/data         one-cycle completion pulse and result to owner
//   md_start/way/w1/w2       MD start, operation select and operands
//   md_hiw/md_low            MD HI/LO write strobes (mthi/mtlo)
//   md_busy, md_hi, md_lo    MD status and result registers
//   err                      sticky watchdog flag
//
// state  | meaning
// IDLE   | arbitrate, accept one request, latch op/a/b/owner
// ISSUE  | one cycle: drive MD controls, finish mt*/mf* immediately
// WAIT   | arithmetic op running; leave when md_busy drops or watchdog expires
// RESP   | response pulse to owner visible; hand priority to the other side

module md_arbiter #(
   parameter int unsigned WDOG = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [2:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   input  logic [2:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic        resp0_valid,
   output logic [31:0] resp0_data,
   output logic        resp1_valid,
   output logic [31:0] resp1_data,
   output logic        md_start,
   output logic [2:0]  md_way,
   output logic [31:0] md_w1,
   output logic [31:0] md_w2,
   output logic        md_hiw,
   output logic        md_low,
   input  logic        md_busy,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic        err
);

   localparam logic [2:0] OP_MFLO = 3'd0;
   localparam logic [2:0] OP_DIVU = 3'd4;
   localparam logic [2:0] OP_MTHI = 3'd5;
   localparam logic [2:0] OP_MTLO = 3'd6;
   localparam logic [2:0] OP_MFHI = 3'd7;

   // Watchdog down-counter is loaded with WDOG-1 so that terminal count
   // (zero) is reached in the WDOG-th WAIT cycle.
   localparam logic [7:0] WD_LOAD = 8'(WDOG - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t      state_q;
   logic        owner_q;
   logic        rr_q;
   logic [2:0]  op_q;
   logic [7:0]  wd_q;
   logic        err_q;
   logic        md_start_q, md_hiw_q, md_low_q;
   logic [2:0]  md_way_q;
   logic [31:0] md_w1_q, md_w2_q;
   logic        resp0_valid_q, resp1_valid_q;
   logic [31:0] resp0_data_q, resp1_data_q;

   logic        grant1_d;
   logic        accept_d;
   logic [2:0]  op_d;
   logic [31:0] a_d, b_d;
   logic        arith_d;
   logic        resp_fire_d;
   logic [31:0] resp_val_d;
   logic        wd_expire_d;

   // Requester 1 wins when it is alone or when both are valid and rr points at it.
   assign grant1_d = req1_valid && (!req0_valid || rr_q);
   assign accept_d = (state_q == S_IDLE) && !reset && (req0_valid || req1_valid);
   assign req0_ready = accept_d && !grant1_d;
   assign req1_ready = accept_d && grant1_d;

   assign op_d    = grant1_d ? req1_op : req0_op;
   assign a_d     = grant1_d ? req1_a  : req0_a;
   assign b_d     = grant1_d ? req1_b  : req0_b;
   assign arith_d = (op_d != OP_MFLO) && (op_d <= OP_DIVU);

   always_comb begin
      resp_fire_d = 1'b0;
      resp_val_d  = '0;
      wd_expire_d = 1'b0;
      case (state_q)
         S_ISSUE: begin
            case (op_q)
               OP_MFHI: begin resp_fire_d = 1'b1; resp_val_d = md_hi; end
               OP_MFLO: begin resp_fire_d = 1'b1; resp_val_d = md_lo; end
               OP_MTHI, OP_MTLO: resp_fire_d = 1'b1;
               default: resp_fire_d = 1'b0;
            endcase
         end
         S_WAIT: begin
            if (!md_busy) begin
               resp_fire_d = 1'b1;
               resp_val_d  = md_lo;
            end else if (wd_q == 8'd0) begin
               resp_fire_d = 1'b1;
               resp_val_d  = 32'hFFFF_FFFF;
               wd_expire_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         owner_q       <= 1'b0;
         rr_q          <= 1'b0;
         op_q          <= '0;
         wd_q          <= '0;
         err_q         <= 1'b0;
         md_start_q    <= 1'b0;
         md_hiw_q      <= 1'b0;
         md_low_q      <= 1'b0;
         md_way_q      <= '0;
         md_w1_q       <= '0;
         md_w2_q       <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp0_data_q  <= '0;
         resp1_data_q  <= '0;
      end else begin
         // MD controls and response strobes are single-cycle pulses.
         md_start_q    <= 1'b0;
         md_hiw_q      <= 1'b0;
         md_low_q      <= 1'b0;
         md_way_q      <= '0;
         md_w1_q       <= '0;
         md_w2_q       <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;

         if (resp_fire_d) begin
            if (owner_q) begin
               resp1_valid_q <= 1'b1;
               resp1_data_q  <= resp_val_d;
            end else begin
               resp0_valid_q <= 1'b1;
               resp0_data_q  <= resp_val_d;
            end
         end
         if (wd_expire_d) err_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (accept_d) begin
                  owner_q    <= grant1_d;
                  op_q       <= op_d;
                  md_w1_q    <= a_d;
                  md_w2_q    <= b_d;
                  md_start_q <= arith_d;
                  md_way_q   <= arith_d ? op_d : 3'd0;
                  md_hiw_q   <= (op_d == OP_MTHI);
                  md_low_q   <= (op_d == OP_MTLO);
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (resp_fire_d) begin
                  state_q <= S_RESP;
               end else begin
                  wd_q    <= WD_LOAD;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (resp_fire_d) state_q <= S_RESP;
               else             wd_q    <= wd_q - 8'd1;
            end
            S_RESP: begin
               rr_q    <= ~owner_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign resp0_valid = resp0_valid_q;
   assign resp1_valid = resp1_valid_q;
   assign resp0_data  = resp0_data_q;
   assign resp1_data  = resp1_data_q;
   assign md_start    = md_start_q;
   assign md_way      = md_way_q;
   assign md_w1       = md_w1_q;
   assign md_w2       = md_w2_q;
   assign md_hiw      = md_hiw_q;
   assign md_low      = md_low_q;
   assign err         = err_q;

endmodule

// File: tb/tb_md_arbiter.sv
// Bench for md_arbiter: behavioural MD unit, table of single operations with
// hand-computed results/latencies, plus arbitration, watchdog and reset
// sequences.
module tb_md_arbiter;
   localparam int WDOG = 16;
   localparam logic [2:0] OP_MFLO = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                          OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_MFHI = 3'd7;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req0_valid = 1'b0, req1_valid = 1'b0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic req0_ready, req1_ready, resp0_valid, resp1_valid;
   logic [31:0] resp0_data, resp1_data;
   logic md_start, md_hiw, md_low, md_busy, err;
   logic [2:0] md_way;
   logic [31:0] md_w1, md_w2, md_hi, md_lo;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   md_arbiter #(.WDOG(WDOG)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp0_data(resp0_data),
      .resp1_valid(resp1_valid), .resp1_data(resp1_data),
      .md_start(md_start), .md_way(md_way), .md_w1(md_w1), .md_w2(md_w2),
      .md_hiw(md_hiw), .md_low(md_low), .md_busy(md_busy),
      .md_hi(md_hi), .md_lo(md_lo), .err(err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural MD unit: busy for 5 (mult) or 10 (div) cycles after start.
   logic md_stuck = 1'b0;
   int md_cnt;
   logic [31:0] hi_m, lo_m, hi_p, lo_p;

   function automatic logic [63:0] md_calc(input logic [2:0] way, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx, sy;
      logic [63:0] ex, ey;
      sx = x; sy = y;
      ex = {{32{x[31]}}, x};
      ey = {{32{y[31]}}, y};
      case (way)
         OP_MULT:  return ex * ey;
         OP_MULTU: return {32'b0, x} * {32'b0, y};
         OP_DIV:   return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
         OP_DIVU:  return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
         default:  return 64'd0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt <= 0; hi_m <= '0; lo_m <= '0; hi_p <= '0; lo_p <= '0;
      end else begin
         if (md_cnt > 0) begin
            md_cnt <= md_cnt - 1;
            if (md_cnt == 1) begin hi_m <= hi_p; lo_m <= lo_p; end
         end
         if (md_start) begin
            {hi_p, lo_p} <= md_calc(md_way, md_w1, md_w2);
            md_cnt <= (md_way == OP_MULT || md_way == OP_MULTU) ? 5 : 10;
         end
         if (md_hiw) hi_m <= md_w1;
         if (md_low) lo_m <= md_w1;
      end
   end
   assign md_busy = md_stuck || (md_cnt != 0);
   assign md_hi = hi_m;
   assign md_lo = lo_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input int p, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
      else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
   endtask

   function automatic logic rdy(input int p);
      return (p == 0) ? req0_ready : req1_ready;
   endfunction

   // Called just after a negedge; returns with valid still held and the
   // handshake cycle number in c0 (that cycle's posedge not yet reached).
   task automatic accept(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int c0, output bit ok);
      ok = 0;
      drive(p, 1'b1, op, a, b);
      for (int k = 0; k < 40 && !ok; k++) begin
         #1;
         if (rdy(p)) ok = 1;
         else @(negedge clk);
      end
      c0 = cyc;
   endtask

   typedef struct {
      int p; logic [2:0] op; logic [31:0] a; logic [31:0] b;
      logic [31:0] exp_d; int lat; logic [2:0] way; logic [2:0] ctl; // ctl = {start,hiw,low}
   } vec_t;

   task automatic do_op(input string nm, input vec_t v);
      int c0, lat, bad;
      bit ok, got;
      logic [31:0] d;
      @(negedge clk);
      accept(v.p, v.op, v.a, v.b, c0, ok);
      chk({nm, "_accept"}, 32'(ok), 32'd1);
      if (!ok) begin drive(v.p, 1'b0, v.op, v.a, v.b); return; end
      @(negedge clk);  // cycle C+1: ISSUE
      chk({nm, "_ctl"}, {29'd0, md_start, md_hiw, md_low}, {29'd0, v.ctl});
      chk({nm, "_way"}, {29'd0, md_way}, {29'd0, v.way});
      chk({nm, "_w"}, md_w1 ^ {md_w2[15:0], md_w2[31:16]}, v.a ^ {v.b[15:0], v.b[31:16]});
      // Valid stays high while in flight: ready must stay low outside IDLE.
      got = 0; bad = 0; lat = 0; d = '0;
      while (!got && (cyc - c0) < 60) begin
         if ((v.p == 0 ? resp1_valid : resp0_valid)) bad++;
         if (req0_ready || req1_ready) bad++;
         if ((v.p == 0 ? resp0_valid : resp1_valid)) begin
            got = 1; lat = cyc - c0; d = (v.p == 0) ? resp0_data : resp1_data;
         end else @(negedge clk);
      end
      drive(v.p, 1'b0, v.op, v.a, v.b);
      chk({nm, "_resp_seen"}, 32'(got), 32'd1);
      chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
      chk({nm, "_data"}, d, v.exp_d);
      chk({nm, "_no_stray"}, 32'(bad), 32'd0);
      @(negedge clk);
      chk({nm, "_pulse1"}, {31'd0, (v.p == 0) ? resp0_valid : resp1_valid}, 32'd0);
      chk({nm, "_hold"}, (v.p == 0) ? resp0_data : resp1_data, v.exp_d);
   endtask

   vec_t tbl[14];

   initial begin
      int c0, rcnt, rbad, gbad, g, i0, i1, last;
      bit ok;
      logic [2:0] ops0[3], ops1[3];
      logic [31:0] a0[3], a1[3];
      int exp_g[6];

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      chk("rst_ctl", {21'd0, req0_ready, req1_ready, resp0_valid, resp1_valid, md_start, md_way, md_hiw, md_low, err}, 32'd0);
      chk("rst_data", resp0_data | resp1_data | md_w1 | md_w2, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ctl", {25'd0, req0_ready, req1_ready, resp0_valid, resp1_valid, md_start, md_hiw, md_low}, 32'd0);

      // ---------------- arbitration: both valid, mt* streams ----------------
      ops0 = '{OP_MTHI, OP_MTLO, OP_MTHI};  a0 = '{32'h1111, 32'h2222, 32'h3333};
      ops1 = '{OP_MTLO, OP_MTHI, OP_MTLO};  a1 = '{32'h4444, 32'h5555, 32'h6666};
      exp_g = '{0, 1, 0, 1, 0, 1};
      i0 = 0; i1 = 0; g = 0; last = -1; rcnt = 0; rbad = 0; gbad = 0;
      for (int t = 0; t < 80 && rcnt < 6; t++) begin
         drive(0, i0 < 3, ops0[i0 < 3 ? i0 : 0], a0[i0 < 3 ? i0 : 0], 32'hDEAD);
         drive(1, i1 < 3, ops1[i1 < 3 ? i1 : 0], a1[i1 < 3 ? i1 : 0], 32'hBEEF);
         #1;
         if (resp0_valid) begin rcnt++; if (last != 0 || resp0_data != 0) rbad++; end
         if (resp1_valid) begin rcnt++; if (last != 1 || resp1_data != 0) rbad++; end
         if (req0_ready && req1_ready) gbad++;
         if (req0_ready) begin if (g >= 6 || exp_g[g] != 0) gbad++; g++; i0++; last = 0; end
         else if (req1_ready) begin if (g >= 6 || exp_g[g] != 1) gbad++; g++; i1++; last = 1; end
         @(negedge clk);
      end
      drive(0, 1'b0, 3'd0, '0, '0);
      drive(1, 1'b0, 3'd0, '0, '0);
      chk("arb_grants", 32'(g), 32'd6);
      chk("arb_order", 32'(gbad), 32'd0);
      chk("arb_resps", 32'(rcnt), 32'd6);
      chk("arb_resp_port", 32'(rbad), 32'd0);

      // ---------------- table of single operations ----------------
      //           p  op        a             b        exp_d         lat way       ctl
      tbl[0]  = '{0, OP_MFLO,  32'h0,        32'h0,   32'h6666,     2, 3'd0,     3'b000};
      tbl[1]  = '{1, OP_MFHI,  32'h0,        32'h0,   32'h3333,     2, 3'd0,     3'b000};
      tbl[2]  = '{0, OP_MULT,  32'hFFFFFFFE, 32'd3,   32'hFFFFFFFA, 8, OP_MULT,  3'b100};
      tbl[3]  = '{0, OP_MFHI,  32'h0,        32'h0,   32'hFFFFFFFF, 2, 3'd0,     3'b000};
      tbl[4]  = '{1, OP_DIVU,  32'd100,      32'd7,   32'd14,      13, OP_DIVU,  3'b100};
      tbl[5]  = '{1, OP_MFHI,  32'h0,        32'h0,   32'd2,        2, 3'd0,     3'b000};
      tbl[6]  = '{0, OP_MTHI,  32'h1234,     32'h99,  32'h0,        2, 3'd0,     3'b010};
      tbl[7]  = '{1, OP_MFHI,  32'h0,        32'h0,   32'h1234,     2, 3'd0,     3'b000};
      tbl[8]  = '{1, OP_MTLO,  32'hABCD,     32'h0,   32'h0,        2, 3'd0,     3'b001};
      tbl[9]  = '{0, OP_MFLO,  32'h0,        32'h0,   32'hABCD,     2, 3'd0,     3'b000};
      tbl[10] = '{0, OP_MULTU, 32'hFFFFFFFF, 32'd2,   32'hFFFFFFFE, 8, OP_MULTU, 3'b100};
      tbl[11] = '{1, OP_MFHI,  32'h0,        32'h0,   32'd1,        2, 3'd0,     3'b000};
      tbl[12] = '{0, OP_DIV,   32'hFFFFFFF9, 32'd2,   32'hFFFFFFFD,13, OP_DIV,   3'b100};
      tbl[13] = '{0, OP_MFHI,  32'h0,        32'h0,   32'hFFFFFFFF, 2, 3'd0,     3'b000};
      for (int i = 0; i < 14; i++) do_op($sformatf("v%0d", i), tbl[i]);

      // ---------------- watchdog ----------------
      chk("err_pre", {31'd0, err}, 32'd0);
      md_stuck = 1'b1;
      do_op("wdog", '{0, OP_MULT, 32'd3, 32'd4, 32'hFFFFFFFF, WDOG + 2, OP_MULT, 3'b100});
      chk("err_set", {31'd0, err}, 32'd1);
      md_stuck = 1'b0;
      do_op("after_wdog", '{0, OP_MULTU, 32'd6, 32'd7, 32'd42, 8, OP_MULTU, 3'b100});
      chk("err_sticky", {31'd0, err}, 32'd1);

      // ---------------- reset in the middle of a divide ----------------
      // rr points at requester 1 here (last owner was 0).
      @(negedge clk);
      accept(1, OP_DIVU, 32'd1000, 32'd10, c0, ok);
      chk("mid_accept", 32'(ok), 32'd1);
      while (cyc < c0 + 4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_ctl", {21'd0, req0_ready, req1_ready, resp0_valid, resp1_valid, md_start, md_way, md_hiw, md_low, err}, 32'd0);
      chk("mid_rst_data", resp0_data | resp1_data | md_w1 | md_w2, 32'd0);
      drive(1, 1'b0, 3'd0, '0, '0);
      rcnt = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (t == 2) reset = 1'b0;
         if (resp0_valid || resp1_valid) rcnt++;
      end
      chk("mid_no_resp", 32'(rcnt), 32'd0);
      // Both valid right after reset: rr was cleared, so requester 0 wins.
      drive(0, 1'b1, OP_MULT, 32'hFFFFFFFD, 32'd5);
      drive(1, 1'b1, OP_MTLO, 32'h77, 32'd0);
      #1;
      chk("rr_after_rst", {30'd0, req0_ready, req1_ready}, 32'b10);
      drive(0, 1'b0, 3'd0, '0, '0);
      drive(1, 1'b0, 3'd0, '0, '0);
      do_op("post_rst_mult", '{0, OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 8, OP_MULT, 3'b100});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
